// File: rtl/rx_deframer_pkg.sv
// Shared definitions for the PLCP receive deframer: FSM states, SIGNAL field layout,
// descrambler taps and SERVICE/SEED lengths.
package rx_deframer_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      SIGNAL  = 3'd1,
      SEED    = 3'd2,
      SERVICE = 3'd3,
      PSDU    = 3'd4,
      TAIL    = 3'd5
   } state_t;

   // SIGNAL field layout, bits received LSB-first
   localparam int SIG_BITS   = 24;
   localparam int RATE_LSB   = 0;
   localparam int RATE_MSB   = 3;
   localparam int RSVD_BIT   = 4;
   localparam int LEN_LSB    = 5;
   localparam int LEN_MSB    = 16;
   localparam int PAR_BIT    = 17;
   localparam int TAIL_LSB   = 18;
   localparam int TAIL_MSB   = 23;
   localparam int SIG_LEN_W  = LEN_MSB - LEN_LSB + 1;

   localparam int LFSR_TAP_A  = 6;
   localparam int LFSR_TAP_B  = 3;
   localparam int SERVICE_LEN = 16;
   localparam int SEED_LEN    = 7;
   localparam int SVC_CHK_LEN = SERVICE_LEN - SEED_LEN;
   localparam int TAIL_BITS   = 6;

endpackage

// File: rtl/rx_descrambler_lfsr.sv
// 7-bit x^7+x^4+1 descrambler: either loads received bits directly (seed recovery)
// or free-runs and XORs its output onto the incoming bit.
module rx_descrambler_lfsr
   import rx_deframer_pkg::*;
(
   input  logic       Clk,
   input  logic       reset,
   input  logic       load_bit,
   input  logic       load_en,
   input  logic       step_en,
   input  logic       din,
   output logic       dout,
   output logic [6:0] state
);

   logic scr_bit;

   assign scr_bit = state[LFSR_TAP_A] ^ state[LFSR_TAP_B];
   assign dout    = din ^ scr_bit;

   always_ff @(posedge Clk) begin
      if (reset) begin
         state <= '0;
      end else if (load_en) begin
         state <= {state[5:0], load_bit};
      end else if (step_en) begin
         state <= {state[5:0], scr_bit};
      end
   end

endmodule

// File: rtl/rx_deframer_param.sv
// Serial PLCP receive deframer: preamble hunt, SIGNAL validation, seed recovery,
// SERVICE check, PSDU descramble/word packing and tail discard.
module rx_deframer_param
   import rx_deframer_pkg::*;
#(
   parameter int PRE_LEN = 11,
   parameter int OUT_W   = 8,
   parameter int LEN_W   = 12,
   parameter int MAX_LEN = 4095,
   parameter int PAD_W   = 6,
   parameter int CHK_SVC = 1
)
(
   input  logic             Clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic [PAD_W-1:0] n_pad,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid,
   output logic [3:0]       rate,
   output logic [LEN_W-1:0] length,
   output logic             sig_valid,
   output logic             frame_done,
   output logic             frame_err,
   output logic             busy
);

   localparam int CNT_W  = LEN_W + 3;
   localparam int ONES_W = $clog2(PRE_LEN + 1);
   localparam int WC_W   = $clog2(OUT_W);
   localparam logic [SIG_LEN_W-1:0] MAX_L = SIG_LEN_W'(MAX_LEN);

   state_t             state;
   logic [ONES_W-1:0]  ones_cnt;
   logic [CNT_W-1:0]   cnt;
   logic [SIG_BITS-1:0] sig;
   logic [PAD_W-1:0]   pad_reg;
   logic               svc_err;
   logic [OUT_W-1:0]   shreg;
   logic [WC_W-1:0]    wcnt;

   logic [SIG_BITS-1:0]  next_sig;
   logic [SIG_LEN_W-1:0] sig_len;
   logic                 sig_ok;
   logic [OUT_W-1:0]     next_word;
   logic [CNT_W-1:0]     psdu_last;
   logic [CNT_W-1:0]     tail_last;
   logic                 desc_bit;
   logic [6:0]           unused_lfsr_state;

   rx_descrambler_lfsr u_lfsr (
      .Clk      (Clk),
      .reset    (reset),
      .load_bit (din),
      .load_en  (din_valid && (state == SEED)),
      .step_en  (din_valid && ((state == SERVICE) || (state == PSDU))),
      .din      (din),
      .dout     (desc_bit),
      .state    (unused_lfsr_state)
   );

   // SIGNAL is checked on the word as it will look once the current bit is shifted in
   always_comb begin
      next_sig  = {din, sig[SIG_BITS-1:1]};
      sig_len   = next_sig[LEN_MSB:LEN_LSB];
      sig_ok    = (^next_sig[PAR_BIT:0] == 1'b0) && !next_sig[RSVD_BIT] &&
                  (next_sig[TAIL_MSB:TAIL_LSB] == '0) && (sig_len != '0) &&
                  (sig_len <= MAX_L) && next_sig[RATE_MSB];
      next_word = {desc_bit, shreg[OUT_W-1:1]};
      psdu_last = {length, 3'b000} - CNT_W'(1);
      tail_last = CNT_W'(pad_reg) + CNT_W'(TAIL_BITS - 1);
   end

   assign busy = (state != HUNT);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state      <= HUNT;
         ones_cnt   <= '0;
         cnt        <= '0;
         sig        <= '0;
         pad_reg    <= '0;
         svc_err    <= 1'b0;
         shreg      <= '0;
         wcnt       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         rate       <= '0;
         length     <= '0;
         sig_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         sig_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (din_valid) begin
            unique case (state)
               HUNT: begin
                  if (din) begin
                     if (ones_cnt != ONES_W'(PRE_LEN)) ones_cnt <= ones_cnt + 1'b1;
                  end else begin
                     if (ones_cnt == ONES_W'(PRE_LEN)) begin
                        state <= SIGNAL;
                        cnt   <= '0;
                     end
                     ones_cnt <= '0;
                  end
               end
               SIGNAL: begin
                  sig <= next_sig;
                  if (cnt == CNT_W'(SIG_BITS - 1)) begin
                     cnt <= '0;
                     if (sig_ok) begin
                        rate      <= next_sig[RATE_MSB:RATE_LSB];
                        length    <= LEN_W'(sig_len);
                        pad_reg   <= n_pad;
                        sig_valid <= 1'b1;
                        state     <= SEED;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               SEED: begin
                  if (cnt == CNT_W'(SEED_LEN - 1)) begin
                     cnt     <= '0;
                     svc_err <= 1'b0;
                     state   <= SERVICE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               SERVICE: begin
                  if (cnt == CNT_W'(SVC_CHK_LEN - 1)) begin
                     cnt <= '0;
                     if ((CHK_SVC != 0) && (svc_err || desc_bit)) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                     end else begin
                        wcnt  <= '0;
                        state <= PSDU;
                     end
                  end else begin
                     svc_err <= svc_err | desc_bit;
                     cnt     <= cnt + 1'b1;
                  end
               end
               PSDU: begin
                  shreg <= next_word;
                  if (wcnt == WC_W'(OUT_W - 1)) begin
                     dout       <= next_word;
                     dout_valid <= 1'b1;
                     wcnt       <= '0;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
                  if (cnt == psdu_last) begin
                     cnt   <= '0;
                     state <= TAIL;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               TAIL: begin
                  if (cnt == tail_last) begin
                     cnt        <= '0;
                     frame_done <= 1'b1;
                     state      <= HUNT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule
